// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - execute-to-memory request bus and memory-stage outputs
interface dmem_responder_if;
    logic        halt;
    logic        bubble_in;
    logic        halt_in;
    logic        is_load_in;
    logic        is_store_in;
    logic [1:0]  size_in;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [3:0]  we;
    logic [4:0]  tgt_in_1;
    logic [4:0]  tgt_in_2;
    logic [31:0] result_in_1;
    logic [31:0] result_in_2;
    logic [31:0] mem_result_out_1;
    logic [31:0] mem_result_out_2;
    logic [4:0]  mem_tgt_1;
    logic [4:0]  mem_tgt_2;
    logic        mem_bubble;
    logic        is_load_mem;
    logic        halt_out;
    logic        misalign_out;
    logic        misalign_flag;
    logic [31:0] misalign_addr;

    // Execute side: drives the request, consumes forwarding/stall signals
    modport master (
        output halt, bubble_in, halt_in, is_load_in, is_store_in, size_in,
               addr, store_data, we, tgt_in_1, tgt_in_2, result_in_1, result_in_2,
        input  mem_result_out_1, mem_result_out_2, mem_tgt_1, mem_tgt_2,
               mem_bubble, is_load_mem, halt_out, misalign_out, misalign_flag,
               misalign_addr
    );

    // Responder side
    modport slave (
        input  halt, bubble_in, halt_in, is_load_in, is_store_in, size_in,
               addr, store_data, we, tgt_in_1, tgt_in_2, result_in_1, result_in_2,
        output mem_result_out_1, mem_result_out_2, mem_tgt_1, mem_tgt_2,
               mem_bubble, is_load_mem, halt_out, misalign_out, misalign_flag,
               misalign_addr
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-lane data RAM and memory-stage register; DMEM_MISALIGN_TRAP_EN enables misalign faults
module dmem_responder #(
    parameter int ADDR_BITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    logic [31:0] mem [2**ADDR_BITS];

    logic                 is_word, is_half;
    logic [1:0]           off;
    logic                 fault;
    logic [7:0]           we_wide;
    logic [3:0]           we_eff;
    logic [63:0]          wdata_wide;
    logic [31:0]          wdata;
    logic [ADDR_BITS-1:0] idx;

    logic [31:0] rdata_q;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        is_load_q, is_load_d;
    logic        fault_q, fault_d;
    logic [31:0] res1_q, res1_d, res2_q, res2_d;
    logic [4:0]  tgt1_q, tgt1_d, tgt2_q, tgt2_d;
    logic        bubble_q, bubble_d;
    logic        halt_out_q, halt_out_d;
    logic [31:0] shifted, load_data;

    logic unused_bits;
    assign unused_bits = ^{bus.addr[31:ADDR_BITS+2], bus.is_store_in};

    // Request decode: lane offset, fault detection, shifted enables and rotated data
    always_comb begin
        is_word = (bus.size_in == 2'd0) || (bus.size_in == 2'd3);
        is_half = (bus.size_in == 2'd1);
`ifdef DMEM_MISALIGN_TRAP_EN
        off   = bus.addr[1:0];
        fault = !bus.bubble_in && (bus.is_load_in || bus.is_store_in) &&
                ((is_word && (bus.addr[1:0] != 2'd0)) || (is_half && bus.addr[0]));
`else
        fault = 1'b0;
        if (is_word)      off = 2'd0;
        else if (is_half) off = {bus.addr[1], 1'b0};
        else              off = bus.addr[1:0];
`endif
        we_wide    = {4'b0000, bus.we} << off;
        we_eff     = we_wide[3:0] & {4{!bus.bubble_in && !bus.halt && !fault}};
        wdata_wide = {bus.store_data, bus.store_data} << {off, 3'b000};
        wdata      = wdata_wide[63:32];
        idx        = bus.addr[ADDR_BITS+1:2];
    end

    // RAM: byte-lane write and read-before-write of the same word; contents never reset
    always_ff @(posedge clk) begin
        if (!rst && !bus.halt) begin
            for (int i = 0; i < 4; i++) begin
                if (we_eff[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata_q <= mem[idx];
        end
    end

    // Next-state of the memory-stage register; everything holds under halt
    always_comb begin
        off_d      = off_q;
        size_d     = size_q;
        is_load_d  = is_load_q;
        fault_d    = fault_q;
        res1_d     = res1_q;
        res2_d     = res2_q;
        tgt1_d     = tgt1_q;
        tgt2_d     = tgt2_q;
        bubble_d   = bubble_q;
        halt_out_d = halt_out_q;
        if (!bus.halt) begin
            off_d      = off;
            size_d     = bus.size_in;
            is_load_d  = bus.is_load_in && !bus.bubble_in;
            fault_d    = fault;
            res1_d     = bus.result_in_1;
            res2_d     = bus.result_in_2;
            tgt1_d     = bus.bubble_in ? 5'd0 : bus.tgt_in_1;
            tgt2_d     = bus.bubble_in ? 5'd0 : bus.tgt_in_2;
            bubble_d   = bus.bubble_in;
            halt_out_d = bus.halt_in && !bus.bubble_in;
        end
    end

    // Memory-stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            is_load_q  <= 1'b0;
            fault_q    <= 1'b0;
            res1_q     <= 32'd0;
            res2_q     <= 32'd0;
            tgt1_q     <= 5'd0;
            tgt2_q     <= 5'd0;
            bubble_q   <= 1'b1;
            halt_out_q <= 1'b0;
        end else begin
            off_q      <= off_d;
            size_q     <= size_d;
            is_load_q  <= is_load_d;
            fault_q    <= fault_d;
            res1_q     <= res1_d;
            res2_q     <= res2_d;
            tgt1_q     <= tgt1_d;
            tgt2_q     <= tgt2_d;
            bubble_q   <= bubble_d;
            halt_out_q <= halt_out_d;
        end
    end

    // Load extract: align the registered word by lane offset and zero-extend
    always_comb begin
        shifted = rdata_q >> {off_q, 3'b000};
        case (size_q)
            2'd1:    load_data = {16'd0, shifted[15:0]};
            2'd2:    load_data = {24'd0, shifted[7:0]};
            default: load_data = rdata_q;
        endcase
        if (fault_q) load_data = 32'd0;
    end

    assign bus.mem_result_out_1 = is_load_q ? load_data : res1_q;
    assign bus.mem_result_out_2 = res2_q;
    assign bus.mem_tgt_1        = tgt1_q;
    assign bus.mem_tgt_2        = tgt2_q;
    assign bus.mem_bubble       = bubble_q;
    assign bus.is_load_mem      = is_load_q;
    assign bus.halt_out         = halt_out_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic        flag_q, flag_d;
    logic [31:0] maddr_q, maddr_d;

    // Sticky capture of the first faulting address
    always_comb begin
        flag_d  = flag_q;
        maddr_d = maddr_q;
        if (!bus.halt && fault && !flag_q) begin
            flag_d  = 1'b1;
            maddr_d = bus.addr;
        end
    end

    // Sticky fault registers, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q  <= 1'b0;
            maddr_q <= 32'd0;
        end else begin
            flag_q  <= flag_d;
            maddr_q <= maddr_d;
        end
    end

    assign bus.misalign_out  = fault_q;
    assign bus.misalign_flag = flag_q;
    assign bus.misalign_addr = maddr_q;
`else
    logic unused_fault;
    assign unused_fault      = fault_q;
    assign bus.misalign_out  = 1'b0;
    assign bus.misalign_flag = 1'b0;
    assign bus.misalign_addr = 32'd0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_w;

    dmem_responder_if dif ();

    dmem_responder #(.ADDR_BITS(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        dif.halt        = 1'b0;
        dif.bubble_in   = 1'b1;
        dif.halt_in     = 1'b0;
        dif.is_load_in  = 1'b0;
        dif.is_store_in = 1'b0;
        dif.size_in     = 2'd0;
        dif.addr        = 32'd0;
        dif.store_data  = 32'd0;
        dif.we          = 4'd0;
        dif.tgt_in_1    = 5'd0;
        dif.tgt_in_2    = 5'd0;
        dif.result_in_1 = 32'd0;
        dif.result_in_2 = 32'd0;
    endtask

    // Present one request for one cycle; returns #1 after the capturing edge
    task automatic req(input logic bub, input logic hi, input logic ld, input logic st,
                       input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] t, input logic [31:0] r);
        dif.halt        = 1'b0;
        dif.bubble_in   = bub;
        dif.halt_in     = hi;
        dif.is_load_in  = ld;
        dif.is_store_in = st;
        dif.size_in     = sz;
        dif.addr        = a;
        dif.store_data  = d;
        dif.we          = !st ? 4'b0000 : (sz == 2'd1) ? 4'b0011 : (sz == 2'd2) ? 4'b0001 : 4'b1111;
        dif.tgt_in_1    = t;
        dif.tgt_in_2    = t + 5'd1;
        dif.result_in_1 = r;
        dif.result_in_2 = ~r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dif.mem_bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble got %b exp 1", dif.mem_bubble); end
        checks++; if (dif.mem_result_out_1 !== 32'd0) begin errors++; $display("FAIL reset_res1 got %h exp 0", dif.mem_result_out_1); end
        checks++; if (dif.misalign_flag !== 1'b0 || dif.misalign_addr !== 32'd0) begin errors++; $display("FAIL reset_misalign got %b/%h exp 0/0", dif.misalign_flag, dif.misalign_addr); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dif.mem_bubble !== 1'b1) begin errors++; $display("FAIL idle_bubble got %b exp 1", dif.mem_bubble); end
        checks++; if (dif.mem_tgt_1 !== 5'd0) begin errors++; $display("FAIL idle_tgt1 got %0d exp 0", dif.mem_tgt_1); end
        checks++; if (dif.is_load_mem !== 1'b0 || dif.halt_out !== 1'b0) begin errors++; $display("FAIL idle_load_halt got %b/%b exp 0/0", dif.is_load_mem, dif.halt_out); end
    endtask

    task automatic test_word();
        req(0, 0, 0, 1, 2'd0, 32'h40, 32'h11223344, 5'd2, 32'h99);
        checks++; if (dif.mem_result_out_1 !== 32'h99) begin errors++; $display("FAIL store_res1 got %h exp 00000099", dif.mem_result_out_1); end
        checks++; if (dif.mem_bubble !== 1'b0 || dif.is_load_mem !== 1'b0) begin errors++; $display("FAIL store_flags got %b/%b exp 0/0", dif.mem_bubble, dif.is_load_mem); end
        req(0, 0, 1, 0, 2'd0, 32'h40, 32'h0, 5'd7, 32'hdead);
        checks++; if (dif.mem_result_out_1 !== 32'h11223344) begin errors++; $display("FAIL load_word got %h exp 11223344", dif.mem_result_out_1); end
        checks++; if (dif.mem_tgt_1 !== 5'd7 || dif.mem_tgt_2 !== 5'd8 || dif.is_load_mem !== 1'b1) begin errors++; $display("FAIL load_word_tgt got %0d/%0d/%b exp 7/8/1", dif.mem_tgt_1, dif.mem_tgt_2, dif.is_load_mem); end
        checks++; if (dif.mem_result_out_2 !== ~32'hdead) begin errors++; $display("FAIL load_word_res2 got %h exp ffff2152", dif.mem_result_out_2); end
    endtask

    task automatic test_byte();
        req(0, 0, 0, 1, 2'd2, 32'h41, 32'hAB, 5'd0, 32'h0);
        req(0, 0, 1, 0, 2'd0, 32'h40, 32'h0, 5'd1, 32'h0);
        checks++; if (dif.mem_result_out_1 !== 32'h1122AB44) begin errors++; $display("FAIL byte_word got %h exp 1122ab44", dif.mem_result_out_1); end
        req(0, 0, 1, 0, 2'd2, 32'h41, 32'h0, 5'd1, 32'h0);
        checks++; if (dif.mem_result_out_1 !== 32'h000000AB) begin errors++; $display("FAIL load_byte41 got %h exp 000000ab", dif.mem_result_out_1); end
        req(0, 0, 1, 0, 2'd2, 32'h43, 32'h0, 5'd1, 32'h0);
        checks++; if (dif.mem_result_out_1 !== 32'h00000011) begin errors++; $display("FAIL load_byte43 got %h exp 00000011", dif.mem_result_out_1); end
        req(0, 0, 1, 0, 2'd1, 32'h40, 32'h0, 5'd1, 32'h0);
        checks++; if (dif.mem_result_out_1 !== 32'h0000AB44) begin errors++; $display("FAIL load_half40 got %h exp 0000ab44", dif.mem_result_out_1); end
    endtask

    task automatic test_half();
        req(0, 0, 0, 1, 2'd1, 32'h42, 32'hBEEF, 5'd0, 32'h0);
        req(0, 0, 1, 0, 2'd1, 32'h42, 32'h0, 5'd1, 32'h0);
        checks++; if (dif.mem_result_out_1 !== 32'h0000BEEF) begin errors++; $display("FAIL load_half42 got %h exp 0000beef", dif.mem_result_out_1); end
        req(0, 0, 1, 0, 2'd0, 32'h40, 32'h0, 5'd3, 32'h0);
        checks++; if (dif.mem_result_out_1 !== 32'hBEEFAB44) begin errors++; $display("FAIL half_word got %h exp beefab44", dif.mem_result_out_1); end
    endtask

    task automatic test_halt();
        dif.halt        = 1'b1;
        dif.bubble_in   = 1'b0;
        dif.halt_in     = 1'b1;
        dif.is_load_in  = 1'b0;
        dif.is_store_in = 1'b1;
        dif.size_in     = 2'd0;
        dif.addr        = 32'h40;
        dif.store_data  = 32'h0;
        dif.we          = 4'b1111;
        dif.tgt_in_1    = 5'd9;
        dif.result_in_1 = 32'h77;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if (dif.mem_result_out_1 !== 32'hBEEFAB44 || dif.mem_tgt_1 !== 5'd3) begin errors++; $display("FAIL halt_hold_%0d got %h/%0d exp beefab44/3", i, dif.mem_result_out_1, dif.mem_tgt_1); end
            checks++; if (dif.is_load_mem !== 1'b1 || dif.mem_bubble !== 1'b0 || dif.halt_out !== 1'b0) begin errors++; $display("FAIL halt_flags_%0d got %b/%b/%b exp 1/0/0", i, dif.is_load_mem, dif.mem_bubble, dif.halt_out); end
        end
        idle();
        req(0, 0, 1, 0, 2'd0, 32'h40, 32'h0, 5'd3, 32'h0);
        checks++; if (dif.mem_result_out_1 !== 32'hBEEFAB44) begin errors++; $display("FAIL halt_no_write got %h exp beefab44", dif.mem_result_out_1); end
    endtask

    task automatic test_halt_out();
        req(0, 1, 0, 0, 2'd0, 32'h0, 32'h0, 5'd1, 32'h5);
        checks++; if (dif.halt_out !== 1'b1 || dif.mem_result_out_1 !== 32'h5) begin errors++; $display("FAIL halt_out_set got %b/%h exp 1/00000005", dif.halt_out, dif.mem_result_out_1); end
        req(1, 1, 0, 0, 2'd0, 32'h0, 32'h0, 5'd1, 32'h5);
        checks++; if (dif.halt_out !== 1'b0 || dif.mem_bubble !== 1'b1) begin errors++; $display("FAIL halt_out_bubble got %b/%b exp 0/1", dif.halt_out, dif.mem_bubble); end
    endtask

    task automatic test_misalign();
        req(0, 0, 0, 1, 2'd0, 32'h41, 32'h55667788, 5'd0, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_w = 32'hBEEFAB44;
        checks++; if (dif.misalign_out !== 1'b1 || dif.misalign_flag !== 1'b1 || dif.misalign_addr !== 32'h41) begin errors++; $display("FAIL trap_store got %b/%b/%h exp 1/1/00000041", dif.misalign_out, dif.misalign_flag, dif.misalign_addr); end
`else
        exp_w = 32'h55667788;
        checks++; if (dif.misalign_out !== 1'b0 || dif.misalign_flag !== 1'b0 || dif.misalign_addr !== 32'h0) begin errors++; $display("FAIL notrap_store got %b/%b/%h exp 0/0/0", dif.misalign_out, dif.misalign_flag, dif.misalign_addr); end
`endif
        req(0, 0, 1, 0, 2'd0, 32'h40, 32'h0, 5'd6, 32'h0);
        checks++; if (dif.mem_result_out_1 !== exp_w) begin errors++; $display("FAIL misalign_store_word got %h exp %h", dif.mem_result_out_1, exp_w); end
        checks++; if (dif.misalign_out !== 1'b0) begin errors++; $display("FAIL misalign_pulse got %b exp 0", dif.misalign_out); end
        req(0, 0, 1, 0, 2'd0, 32'h42, 32'h0, 5'd4, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (dif.mem_result_out_1 !== 32'h0 || dif.mem_tgt_1 !== 5'd4 || dif.misalign_addr !== 32'h41) begin errors++; $display("FAIL trap_load got %h/%0d/%h exp 0/4/00000041", dif.mem_result_out_1, dif.mem_tgt_1, dif.misalign_addr); end
`else
        checks++; if (dif.mem_result_out_1 !== 32'h55667788 || dif.mem_tgt_1 !== 5'd4) begin errors++; $display("FAIL notrap_load got %h/%0d exp 55667788/4", dif.mem_result_out_1, dif.mem_tgt_1); end
`endif
    endtask

    task automatic test_bubble();
        req(1, 0, 1, 0, 2'd0, 32'h40, 32'h0, 5'd5, 32'h0);
        checks++; if (dif.mem_tgt_1 !== 5'd0 || dif.is_load_mem !== 1'b0 || dif.mem_bubble !== 1'b1) begin errors++; $display("FAIL bubble_load got %0d/%b/%b exp 0/0/1", dif.mem_tgt_1, dif.is_load_mem, dif.mem_bubble); end
        req(1, 0, 0, 1, 2'd0, 32'h40, 32'hFFFFFFFF, 5'd0, 32'h0);
        req(0, 0, 1, 0, 2'd0, 32'h40, 32'h0, 5'd5, 32'h0);
        checks++; if (dif.mem_result_out_1 !== exp_w) begin errors++; $display("FAIL bubble_store got %h exp %h", dif.mem_result_out_1, exp_w); end
    endtask

    task automatic test_reset_mid();
        req(0, 0, 0, 1, 2'd0, 32'h80, 32'hCAFEF00D, 5'd0, 32'h0);
        dif.bubble_in   = 1'b0;
        dif.is_store_in = 1'b1;
        dif.size_in     = 2'd0;
        dif.addr        = 32'h80;
        dif.store_data  = 32'h12345678;
        dif.we          = 4'b1111;
        dif.tgt_in_1    = 5'd12;
        rst = 1'b1;
        #1;
        checks++; if (dif.mem_bubble !== 1'b1 || dif.mem_tgt_1 !== 5'd0) begin errors++; $display("FAIL async_reset got %b/%0d exp 1/0", dif.mem_bubble, dif.mem_tgt_1); end
        @(posedge clk);
        #1;
        checks++; if (dif.mem_result_out_1 !== 32'd0 || dif.misalign_flag !== 1'b0) begin errors++; $display("FAIL mid_reset got %h/%b exp 0/0", dif.mem_result_out_1, dif.misalign_flag); end
        rst = 1'b0;
        req(0, 0, 1, 0, 2'd0, 32'h80, 32'h0, 5'd2, 32'h0);
        checks++; if (dif.mem_result_out_1 !== 32'hCAFEF00D) begin errors++; $display("FAIL reset_drop_write got %h exp cafef00d", dif.mem_result_out_1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_w  = 32'd0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_halt();
        test_halt_out();
        test_misalign();
        test_bubble();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
